// File: rtl/tmp101_pkg.sv
// Shared types and constants for the TMP101 temperature reader.
package tmp101_pkg;

    localparam logic [7:0] TMP101_ADDR_READ = 8'b1001_0001;
    localparam int         TEMP_W           = 12;
    localparam int         LSB_SHIFT        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_MSB,
        ST_WAIT_LSB,
        ST_WAIT_DONE,
        ST_CONVERT,
        ST_ERR
    } state_t;

    // The TMP101 left-justifies its 12-bit result across the two bytes.
    function automatic logic [TEMP_W-1:0] assemble_temp(input logic [7:0] msb, input logic [7:0] lsb);
        return {msb, lsb[7:LSB_SHIFT]};
    endfunction

endpackage

// File: rtl/tmp101_temperature_reader_if.sv
// Handshake between the temperature reader (master) and the I2C controller/data unit (slave).
interface tmp101_temperature_reader_if;

    logic       Go;
    logic       I2CBusy;
    logic       ByteReady;
    logic [7:0] ReceivedData;
    logic       AckError;

    modport master (
        output Go,
        input  I2CBusy,
        input  ByteReady,
        input  ReceivedData,
        input  AckError
    );

    modport slave (
        input  Go,
        output I2CBusy,
        output ByteReady,
        output ReceivedData,
        output AckError
    );

endinterface

// File: rtl/tmp101_temperature_reader_sample_tick_gen.sv
// Free-running divider: one-cycle tick every DIVIDE cycles while enabled, held at zero otherwise.
module sample_tick_gen #(
    parameter int unsigned DIVIDE = 15000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned      CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap = (r_count == LAST);
    assign o_tick = i_enable && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_enable || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tmp101_temperature_reader.sv
// Periodic TMP101 read sequencer: pulses Go, captures MSB/LSB, publishes a 12-bit temperature.
// Define TEMP_AVG_EN to output the running average of the last four samples instead of the raw one.
module tmp101_temperature_reader
    import tmp101_pkg::*;
#(
    parameter int unsigned ClockFrequency = 60000000,
    parameter int unsigned SampleRate     = 4,
    parameter int unsigned TimeoutCycles  = 200000
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic                          Enable,
    tmp101_temperature_reader_if.master   bus,
    output logic [TEMP_W-1:0]             Temperature,
    output logic [7:0]                    TempInteger,
    output logic [3:0]                    TempFraction,
    output logic                          TempValid,
    output logic                          Error
);

    localparam int unsigned     TICK_DIV = ClockFrequency / SampleRate;
    localparam int unsigned     TO_W     = $clog2(TimeoutCycles + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TimeoutCycles - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_tick;
    logic              w_timeout;
    logic [TO_W-1:0]   r_to_cnt;
    logic [7:0]        r_msb;
    logic [7:0]        r_lsb;
    logic              r_go;
    logic              r_valid;
    logic              r_error;
    logic [TEMP_W-1:0] r_temp;
    logic [TEMP_W-1:0] w_sample;
    logic [TEMP_W-1:0] w_result;

    sample_tick_gen #(
        .DIVIDE (TICK_DIV)
    ) u_tick (
        .clk      (clock),
        .rst_n    (Reset),
        .i_enable (Enable),
        .o_tick   (w_tick)
    );

    assign w_timeout = (r_to_cnt == TO_LAST);
    assign w_sample  = assemble_temp(r_msb, r_lsb);

    // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_tick && !bus.I2CBusy) w_state_next = ST_START;
            ST_START:     w_state_next = ST_WAIT_MSB;
            ST_WAIT_MSB: begin
                if (bus.AckError)       w_state_next = ST_ERR;
                else if (bus.ByteReady) w_state_next = ST_WAIT_LSB;
                else if (w_timeout)     w_state_next = ST_ERR;
            end
            ST_WAIT_LSB: begin
                if (bus.AckError)       w_state_next = ST_ERR;
                else if (bus.ByteReady) w_state_next = ST_WAIT_DONE;
                else if (w_timeout)     w_state_next = ST_ERR;
            end
            ST_WAIT_DONE: begin
                if (bus.AckError)       w_state_next = ST_ERR;
                else if (!bus.I2CBusy)  w_state_next = ST_CONVERT;
                else if (w_timeout)     w_state_next = ST_ERR;
            end
            ST_CONVERT:   w_state_next = ST_IDLE;
            ST_ERR:       if (!bus.I2CBusy) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

`ifdef TEMP_AVG_EN
    logic [TEMP_W-1:0]        r_hist [4];
    logic                     r_hist_full;
    logic [TEMP_W-1:0]        w_hist_next [4];
    logic signed [TEMP_W+1:0] w_sum;
    logic signed [TEMP_W+1:0] w_avg;

    // The first sample after reset fills the whole history so the average starts at that sample.
    always_comb begin
        for (int i = 0; i < 4; i++) w_hist_next[i] = w_sample;
        if (r_hist_full) begin
            for (int i = 1; i < 4; i++) w_hist_next[i] = r_hist[i-1];
        end
        w_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum = w_sum + {{2{w_hist_next[i][TEMP_W-1]}}, w_hist_next[i]};
        end
        w_avg    = w_sum >>> 2;
        w_result = w_avg[TEMP_W-1:0];
    end

    // NOTE: the history is only four words, so it is reset with the rest of the state rather than left as RAM.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_hist_full <= 1'b0;
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
        end else if (r_state == ST_CONVERT) begin
            r_hist_full <= 1'b1;
            for (int i = 0; i < 4; i++) r_hist[i] <= w_hist_next[i];
        end
    end
`else
    assign w_result = w_sample;
`endif

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_to_cnt <= '0;
            r_msb    <= '0;
            r_lsb    <= '0;
            r_go     <= 1'b0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
            r_temp   <= '0;
        end else begin
            r_state <= w_state_next;
            r_go    <= (w_state_next == ST_START);
            r_valid <= (r_state == ST_CONVERT);

            // Restarts on every state change, so each WAIT_* state gets a full budget.
            if (w_state_next != r_state)  r_to_cnt <= '0;
            else if (!w_timeout)          r_to_cnt <= r_to_cnt + TO_W'(1);

            if (r_state == ST_WAIT_MSB && bus.ByteReady && !bus.AckError) r_msb <= bus.ReceivedData;
            if (r_state == ST_WAIT_LSB && bus.ByteReady && !bus.AckError) r_lsb <= bus.ReceivedData;

            if (r_state == ST_CONVERT) begin
                r_temp  <= w_result;
                r_error <= 1'b0;
            end else if (w_state_next == ST_ERR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.Go       = r_go;
    assign TempValid    = r_valid;
    assign Error        = r_error;
    assign Temperature  = r_temp;
    assign TempInteger  = r_temp[TEMP_W-1:LSB_SHIFT];
    assign TempFraction = r_temp[LSB_SHIFT-1:0];

endmodule

// File: tb/tb_tmp101_temperature_reader.sv
// Directed self-checking bench for tmp101_temperature_reader with a scripted I2C controller.
module tb_tmp101_temperature_reader;

    logic        clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic [11:0] Temperature;
    logic [7:0]  TempInteger;
    logic [3:0]  TempFraction;
    logic        TempValid;
    logic        Error;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int go_count     = 0;
    int valid_count  = 0;
    int go_busy_count = 0;
    logic [11:0] last_temp = 12'h000;

    tmp101_temperature_reader_if bus ();

    tmp101_temperature_reader #(
        .ClockFrequency (400),
        .SampleRate     (4),
        .TimeoutCycles  (60)
    ) dut (
        .clock        (clock),
        .Reset        (Reset),
        .Enable       (Enable),
        .bus          (bus),
        .Temperature  (Temperature),
        .TempInteger  (TempInteger),
        .TempFraction (TempFraction),
        .TempValid    (TempValid),
        .Error        (Error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.Go)                 go_count      <= go_count + 1;
        if (bus.Go && bus.I2CBusy)  go_busy_count <= go_busy_count + 1;
        if (TempValid)              valid_count   <= valid_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step(1);
            if (bus.Go) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_byte(input logic [7:0] d, input bit ack);
        bus.ByteReady    = 1'b1;
        bus.ReceivedData = d;
        bus.AckError     = ack;
        step(1);
        bus.ByteReady    = 1'b0;
        bus.AckError     = 1'b0;
        bus.ReceivedData = 8'h00;
    endtask

`ifdef TEMP_AVG_EN
    logic [11:0] m_hist [4];
    bit          m_full = 1'b0;

    task automatic avg_model(input logic [11:0] s, output logic [11:0] e);
        int sum;
        if (!m_full) begin
            for (int i = 0; i < 4; i++) m_hist[i] = s;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s;
        end
        m_full = 1'b1;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'($signed(m_hist[i]));
        e = 12'(sum >>> 2);
    endtask
`endif

    // One complete read served by the scripted controller; raw is the hand-computed {MSB, LSB[7:4]}.
    task automatic do_read(input string tag, input logic [7:0] msb, input logic [7:0] lsb,
                           input logic [11:0] raw, input bit drop_en);
        bit          ok;
        int          v0;
        logic [11:0] e;
`ifdef TEMP_AVG_EN
        avg_model(raw, e);
`else
        e = raw;
`endif
        wait_go(ok);
        check({tag, "_go"}, 32'(ok), 32'd1);
        if (ok) begin
            if (drop_en) Enable = 1'b0;
            step(1);
            bus.I2CBusy = 1'b1;
            step(2);
            pulse_byte(msb, 1'b0);
            step(3);
            pulse_byte(lsb, 1'b0);
            step(2);
            v0 = valid_count;
            bus.I2CBusy = 1'b0;
            step(1);
            check({tag, "_valid_early"}, 32'(TempValid), 32'd0);
            step(1);
            check({tag, "_valid"},  32'(TempValid),    32'd1);
            check({tag, "_temp"},   32'(Temperature),  32'(e));
            check({tag, "_int"},    32'(TempInteger),  32'(e[11:4]));
            check({tag, "_frac"},   32'(TempFraction), 32'(e[3:0]));
            check({tag, "_error"},  32'(Error),        32'd0);
            last_temp = e;
            step(1);
            check({tag, "_valid_end"},   32'(TempValid),       32'd0);
            check({tag, "_valid_count"}, 32'(valid_count - v0), 32'd1);
        end
    endtask

    initial begin
        bit ok;
        int c1;
        int v0;
        int g0;

        Reset            = 1'b0;
        Enable           = 1'b0;
        bus.I2CBusy      = 1'b0;
        bus.ByteReady    = 1'b0;
        bus.AckError     = 1'b0;
        bus.ReceivedData = 8'h00;
        step(3);
        check("rst_temp",  32'(Temperature),  32'd0);
        check("rst_int",   32'(TempInteger),  32'd0);
        check("rst_frac",  32'(TempFraction), 32'd0);
        check("rst_valid", 32'(TempValid),    32'd0);
        check("rst_error", 32'(Error),        32'd0);
        check("rst_go",    32'(bus.Go),       32'd0);
        Reset = 1'b1;

        g0 = go_count;
        step(150);
        check("no_go_disabled", 32'(go_count - g0), 32'd0);
        Enable = 1'b1;

        do_read("s100", 8'h10, 8'h00, 12'h100, 1'b0);
        do_read("s104", 8'h10, 8'h40, 12'h104, 1'b0);
        do_read("s108", 8'h10, 8'h80, 12'h108, 1'b0);
        do_read("s10c", 8'h10, 8'hC0, 12'h10C, 1'b0);
        do_read("t25",  8'h19, 8'h00, 12'h190, 1'b0);
        do_read("tm25", 8'hE7, 8'h00, 12'hE70, 1'b0);
        do_read("tmax", 8'h7F, 8'hF0, 12'h7FF, 1'b0);
        do_read("tmh",  8'hFF, 8'h80, 12'hFF8, 1'b0);

        // Unanswered Go: measures the tick period and exercises the WAIT_MSB timeout.
        wait_go(ok);
        check("per_go1", 32'(ok), 32'd1);
        c1 = cyc;
        v0 = valid_count;
        step(30);
        check("per_err_early", 32'(Error), 32'd0);
        wait_go(ok);
        check("per_go2",     32'(ok),              32'd1);
        check("per_cycles",  32'(cyc - c1),        32'd100);
        check("per_err",     32'(Error),           32'd1);
        check("per_temp",    32'(Temperature),     32'(last_temp));
        check("per_novalid", 32'(valid_count - v0), 32'd0);

        step(2);
        check("busy_err_held", 32'(Error), 32'd1);
        g0 = go_count;
        bus.I2CBusy = 1'b1;
        step(250);
        check("busy_no_go", 32'(go_count - g0), 32'd0);
        bus.I2CBusy = 1'b0;
        do_read("clr", 8'h00, 8'h10, 12'h001, 1'b0);

        // NACK arriving together with a byte strobe must win.
        wait_go(ok);
        check("nack_go", 32'(ok), 32'd1);
        step(1);
        bus.I2CBusy = 1'b1;
        step(2);
        v0 = valid_count;
        pulse_byte(8'h55, 1'b1);
        step(1);
        check("nack_err",  32'(Error),       32'd1);
        check("nack_temp", 32'(Temperature), 32'(last_temp));
        step(3);
        bus.I2CBusy = 1'b0;
        step(4);
        check("nack_novalid",  32'(valid_count - v0), 32'd0);
        check("nack_err_held", 32'(Error),            32'd1);
        do_read("nclr", 8'h19, 8'h00, 12'h190, 1'b0);

        wait_go(ok);
        check("to_go", 32'(ok), 32'd1);
        step(1);
        bus.I2CBusy = 1'b1;
        step(2);
        pulse_byte(8'h30, 1'b0);
        step(20);
        check("to_err_early", 32'(Error), 32'd0);
        step(60);
        check("to_err",  32'(Error),       32'd1);
        check("to_temp", 32'(Temperature), 32'(last_temp));
        bus.I2CBusy = 1'b0;
        step(3);

        wait_go(ok);
        check("mr_go", 32'(ok), 32'd1);
        step(1);
        bus.I2CBusy = 1'b1;
        step(2);
        pulse_byte(8'h30, 1'b0);
        step(2);
        Reset = 1'b0;
        step(1);
        check("mr_temp",  32'(Temperature),  32'd0);
        check("mr_int",   32'(TempInteger),  32'd0);
        check("mr_frac",  32'(TempFraction), 32'd0);
        check("mr_valid", 32'(TempValid),    32'd0);
        check("mr_error", 32'(Error),        32'd0);
        check("mr_go",    32'(bus.Go),       32'd0);
`ifdef TEMP_AVG_EN
        m_full = 1'b0;
`endif
        Reset       = 1'b1;
        bus.I2CBusy = 1'b0;
        step(2);

        do_read("endrop", 8'h20, 8'h00, 12'h200, 1'b1);
        g0 = go_count;
        step(250);
        check("endrop_no_go", 32'(go_count - g0), 32'd0);

        check("go_while_busy", 32'(go_busy_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
